// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath types, default widths and the rounding-constant helper.
package fft_pkg;
  localparam int DEF_W    = 16;
  localparam int DEF_TW_W = 16;
  typedef struct packed {
    logic signed [DEF_W-1:0] re;
    logic signed [DEF_W-1:0] im;
  } cplx_t;
  typedef struct packed {
    logic signed [DEF_TW_W-1:0] re;
    logic signed [DEF_TW_W-1:0] im;
  } tw_t;
  // Half an LSB of the Q1.(tw_w-1) product, for round-half-up before the shift.
  function automatic logic [63:0] rnd_const(input int tw_w);
    return 64'd1 << (tw_w - 2);
  endfunction
endpackage

// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: valid/ready sample-pair bus into and out of the butterfly.
interface butterfly_pipe_if
  import fft_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TW_W = DEF_TW_W
);
  logic                 in_valid, in_ready, inv, scale;
  logic                 out_valid, out_ready;
  logic signed [W-1:0]  Data_A_Real, Data_A_Im, Data_B_Real, Data_B_Im;
  logic [2*TW_W-1:0]    Win;
  logic signed [W-1:0]  O_A_Real, O_A_Im, O_B_Real, O_B_Im;
  modport slave (
    input  in_valid, Data_A_Real, Data_A_Im, Data_B_Real, Data_B_Im, Win, inv, scale, out_ready,
    output in_ready, out_valid, O_A_Real, O_A_Im, O_B_Real, O_B_Im
  );
  modport master (
    output in_valid, Data_A_Real, Data_A_Im, Data_B_Real, Data_B_Im, Win, inv, scale, out_ready,
    input  in_ready, out_valid, O_A_Real, O_A_Im, O_B_Real, O_B_Im
  );
endinterface

// File: rtl/cmul_pipe.sv
// cmul_pipe: registered full-precision complex multiply B*W with optional twiddle conjugation.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TW_W = DEF_TW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [W-1:0]      b_re_i,
  input  logic signed [W-1:0]      b_im_i,
  input  logic signed [TW_W-1:0]   w_re_i,
  input  logic signed [TW_W-1:0]   w_im_i,
  input  logic                     conj_i,
  output logic signed [W+TW_W:0]   p_re_o,
  output logic signed [W+TW_W:0]   p_im_o
);
  localparam int PW = W + TW_W + 1;
  // One extra twiddle bit so negating the most negative imaginary part is exact.
  logic signed [TW_W:0] wr, wi, wi_x;
  logic signed [PW-1:0] rr, ii, ri, ir, p_re_d, p_im_d, p_re_q, p_im_q;
  always_comb begin
    wr     = {w_re_i[TW_W-1], w_re_i};
    wi_x   = {w_im_i[TW_W-1], w_im_i};
    wi     = conj_i ? -wi_x : wi_x;
    rr     = PW'(b_re_i) * PW'(wr);
    ii     = PW'(b_im_i) * PW'(wi);
    ri     = PW'(b_re_i) * PW'(wi);
    ir     = PW'(b_im_i) * PW'(wr);
    p_re_d = rr - ii;
    p_im_d = ri + ir;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_re_q <= '0;
      p_im_q <= '0;
    end else if (en_i) begin
      p_re_q <= p_re_d;
      p_im_q <= p_im_d;
    end
  end
  assign p_re_o = p_re_q;
  assign p_im_o = p_im_q;
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly A+/-W*B with valid/ready, inverse, scaling, sticky ovf.
// Define BFLY_SAT_EN to saturate overflowing outputs; otherwise they wrap.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int TW_W = DEF_TW_W
) (
  input  logic             clk,
  input  logic             rst,
  butterfly_pipe_if.slave  bus,
  input  logic             clr_ovf,
  output logic             ovf
);
  localparam int PW = W + TW_W + 1;
  localparam int SW = W + 2;
  localparam logic signed [PW-1:0] RND  = PW'(rnd_const(TW_W));
  localparam logic signed [SW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {3'b111, {(W-1){1'b0}}};
  logic                 en;
  logic                 v1_q, v2_q, v3_q, sc1_q, sc2_q, ovf3_q, ovf_q;
  logic signed [W-1:0]  a_re_q, a_im_q;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [SW-1:0] pr_re, pr_im, sa_re_d, sa_im_d, sb_re_d, sb_im_d;
  logic signed [SW-1:0] sa_re_q, sa_im_q, sb_re_q, sb_im_q;
  logic signed [W-1:0]  ar_d, ai_d, br_d, bi_d, ar_q, ai_q, br_q, bi_q;
  logic [3:0]           ov;
  // Optional halving with round-half-up, then narrowing; returns {overflow, value}.
  function automatic logic [W:0] narrow(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] t;
    logic                 o;
    t = sc ? (s + SW'(1)) >>> 1 : s;
    o = (t > MAXV) || (t < MINV);
`ifdef BFLY_SAT_EN
    return {o, o ? (t[SW-1] ? MINV[W-1:0] : MAXV[W-1:0]) : t[W-1:0]};
`else
    return {o, t[W-1:0]};
`endif
  endfunction
  assign en           = bus.out_ready || !v3_q;
  assign bus.in_ready = en;
  cmul_pipe #(.W(W), .TW_W(TW_W)) u_cmul (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .b_re_i (bus.Data_B_Real),
    .b_im_i (bus.Data_B_Im),
    .w_re_i (bus.Win[2*TW_W-1:TW_W]),
    .w_im_i (bus.Win[TW_W-1:0]),
    .conj_i (bus.inv),
    .p_re_o (p_re),
    .p_im_o (p_im)
  );
  always_comb begin
    pr_re   = SW'((p_re + RND) >>> (TW_W - 1));
    pr_im   = SW'((p_im + RND) >>> (TW_W - 1));
    sa_re_d = SW'(a_re_q) + pr_re;
    sa_im_d = SW'(a_im_q) + pr_im;
    sb_re_d = SW'(a_re_q) - pr_re;
    sb_im_d = SW'(a_im_q) - pr_im;
    {ov[0], ar_d} = narrow(sa_re_q, sc2_q);
    {ov[1], ai_d} = narrow(sa_im_q, sc2_q);
    {ov[2], br_d} = narrow(sb_re_q, sc2_q);
    {ov[3], bi_d} = narrow(sb_im_q, sc2_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1_q, v2_q, v3_q, sc1_q, sc2_q, ovf3_q, ovf_q} <= '0;
      {a_re_q, a_im_q} <= '0;
      {sa_re_q, sa_im_q, sb_re_q, sb_im_q} <= '0;
      {ar_q, ai_q, br_q, bi_q} <= '0;
    end else begin
      ovf_q <= (ovf_q && !clr_ovf) || (v3_q && bus.out_ready && ovf3_q);
      if (en) begin
        v1_q    <= bus.in_valid;
        a_re_q  <= bus.Data_A_Real;
        a_im_q  <= bus.Data_A_Im;
        sc1_q   <= bus.scale;
        v2_q    <= v1_q;
        sc2_q   <= sc1_q;
        sa_re_q <= sa_re_d;
        sa_im_q <= sa_im_d;
        sb_re_q <= sb_re_d;
        sb_im_q <= sb_im_d;
        v3_q    <= v2_q;
        ovf3_q  <= |ov;
        ar_q    <= ar_d;
        ai_q    <= ai_d;
        br_q    <= br_d;
        bi_q    <= bi_d;
      end
    end
  end
  assign bus.out_valid = v3_q;
  assign bus.O_A_Real  = ar_q;
  assign bus.O_A_Im    = ai_q;
  assign bus.O_B_Real  = br_q;
  assign bus.O_B_Im    = bi_q;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed self-checking bench for butterfly_pipe at W=16, TW_W=16.
module tb_butterfly_pipe;
  import fft_pkg::*;
  logic clk = 1'b0, rst = 1'b1, clr_ovf = 1'b0, ovf;
  int n_chk = 0, n_fail = 0;
`ifdef BFLY_SAT_EN
  localparam int OVF_AR = 32767;
`else
  localparam int OVF_AR = -3;
`endif
  butterfly_pipe_if #(.W(16), .TW_W(16)) bus ();
  butterfly_pipe #(.W(16), .TW_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_ovf (clr_ovf),
    .ovf     (ovf)
  );
  always #5 clk = ~clk;

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction
  function automatic cplx_t oa();
    return {bus.O_A_Real, bus.O_A_Im};
  endfunction
  function automatic cplx_t ob();
    return {bus.O_B_Real, bus.O_B_Im};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input cplx_t a, input cplx_t b, input int wr, input int wi, input logic iv, input logic sc);
    bus.Data_A_Real = a.re;
    bus.Data_A_Im   = a.im;
    bus.Data_B_Real = b.re;
    bus.Data_B_Im   = b.im;
    bus.Win         = {16'(wr), 16'(wi)};
    bus.inv         = iv;
    bus.scale       = sc;
  endtask
  task automatic send_one(input cplx_t a, input cplx_t b, input int wr, input int wi, input logic iv,
                          input logic sc, output int lat);
    drive(a, b, wr, wi, iv, sc);
    bus.in_valid = 1'b1;
    step;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      step;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b ovf=%b exp 0 0", bus.out_valid, ovf);
    end
    n_chk++;
    if ({oa(), ob()} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %h exp 0", {oa(), ob()});
    end
    rst = 1'b0;
    step;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    cplx_t ga, gb;
    send_one(mk(1000, 0), mk(500, 0), 32767, 0, 1'b0, 1'b0, lat);
    ga = oa();
    gb = ob();
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d exp 3", lat);
    end
    n_chk++;
    if (ga !== mk(1500, 0) || gb !== mk(500, 0)) begin
      n_fail++;
      $display("FAIL basic_out: got A=(%0d,%0d) B=(%0d,%0d) exp A=(1500,0) B=(500,0)", ga.re, ga.im, gb.re, gb.im);
    end
    step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: out_valid=%b ovf=%b exp 0 0", bus.out_valid, ovf);
    end
  endtask

  task automatic test_inverse;
    int lat;
    cplx_t ga, gb;
    for (int i = 0; i < 2; i++) begin
      send_one(mk(0, 0), mk(0, 1000), 0, 32767, i[0], 1'b0, lat);
      ga = oa();
      gb = ob();
      n_chk++;
      if (ga !== mk(i ? 1000 : -1000, 0) || gb !== mk(i ? -1000 : 1000, 0) || lat !== 3) begin
        n_fail++;
        $display("FAIL inv%0d_out: got A=(%0d,%0d) B=(%0d,%0d) lat=%0d exp A=(%0d,0) B=(%0d,0) lat=3",
                 i, ga.re, ga.im, gb.re, gb.im, lat, i ? 1000 : -1000, i ? -1000 : 1000);
      end
      step;
    end
  endtask

  task automatic test_overflow;
    int lat;
    cplx_t ga, gb;
    send_one(mk(32767, 0), mk(32767, 0), 32767, 0, 1'b0, 1'b0, lat);
    ga = oa();
    gb = ob();
    n_chk++;
    if (ga !== mk(OVF_AR, 0) || gb !== mk(1, 0)) begin
      n_fail++;
      $display("FAIL ovf_out: got A=(%0d,%0d) B=(%0d,%0d) exp A=(%0d,0) B=(1,0)", ga.re, ga.im, gb.re, gb.im, OVF_AR);
    end
    step;
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b exp 1", ovf);
    end
  endtask

  task automatic test_ovf_clear;
    int lat;
    send_one(mk(32767, 0), mk(32767, 0), 32767, 0, 1'b0, 1'b0, lat);
    clr_ovf = 1'b1;
    step;
    clr_ovf = 1'b0;
    n_chk++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b exp 1", ovf);
    end
    clr_ovf = 1'b1;
    step;
    clr_ovf = 1'b0;
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b exp 0", ovf);
    end
  endtask

  task automatic test_scale;
    int lat;
    cplx_t ga, gb;
    send_one(mk(32767, 0), mk(32767, 0), 32767, 0, 1'b0, 1'b1, lat);
    ga = oa();
    gb = ob();
    n_chk++;
    if (ga !== mk(32767, 0) || gb !== mk(1, 0)) begin
      n_fail++;
      $display("FAIL scale_big: got A=(%0d,%0d) B=(%0d,%0d) exp A=(32767,0) B=(1,0)", ga.re, ga.im, gb.re, gb.im);
    end
    step;
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL scale_no_ovf: got %b exp 0", ovf);
    end
    send_one(mk(-3, 5), mk(0, 0), 0, 0, 1'b0, 1'b1, lat);
    ga = oa();
    gb = ob();
    n_chk++;
    if (ga !== mk(-1, 3) || gb !== mk(-1, 3)) begin
      n_fail++;
      $display("FAIL scale_round: got A=(%0d,%0d) B=(%0d,%0d) exp A=(-1,3) B=(-1,3)", ga.re, ga.im, gb.re, gb.im);
    end
    step;
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, occ = 0, extra = 0;
    logic stalled = 1'b0, saw_full = 1'b0, ix, ox;
    logic [63:0] held = '0, cur, exp_o;
    for (int c = 0; c < 40 && got < 5; c++) begin
      bus.out_ready = !(c >= 2 && c <= 6);
      if (sent < 5) drive(mk(100 * (sent + 1), -50 * (sent + 1)), mk(10 * (sent + 1), 0), 32767, 0, 1'b0, 1'b0);
      bus.in_valid = (sent < 5);
      #1;
      cur = {oa(), ob()};
      n_chk++;
      if (bus.in_ready !== !(occ == 3 && !bus.out_ready)) begin
        n_fail++;
        $display("FAIL stream_in_ready c=%0d: got %b exp %b", c, bus.in_ready, !(occ == 3 && !bus.out_ready));
      end
      if (stalled) begin
        n_chk++;
        if (cur !== held || bus.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_hold c=%0d: got %h valid=%b exp %h valid=1", c, cur, bus.out_valid, held);
        end
      end
      ox = bus.out_valid && bus.out_ready;
      if (ox) begin
        exp_o = {mk(110 * (got + 1), -50 * (got + 1)), mk(90 * (got + 1), -50 * (got + 1))};
        n_chk++;
        if (cur !== exp_o) begin
          n_fail++;
          $display("FAIL stream_out%0d: got %h exp %h", got, cur, exp_o);
        end
        got++;
      end
      ix = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_full = 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      held = cur;
      occ += int'(ix) - int'(ox);
      sent += int'(ix);
      step;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) extra++;
      step;
    end
    n_chk++;
    if (got !== 5 || extra !== 0 || saw_full !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_count: got=%0d extra=%0d full=%b exp 5 0 1", got, extra, saw_full);
    end
  endtask

  task automatic test_rst_midflight;
    int lat, extra = 0;
    send_one(mk(32767, 0), mk(32767, 0), 32767, 0, 1'b0, 1'b0, lat);
    step;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(mk(100 * k, -50 * k), mk(10 * k, 0), 32767, 0, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      step;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: out_valid=%b ovf=%b exp 1 1", bus.out_valid, ovf);
    end
    rst = 1'b1;
    step;
    n_chk++;
    if (bus.out_valid !== 1'b0 || ovf !== 1'b0 || {oa(), ob()} !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b ovf=%b out=%h exp 0 0 0", bus.out_valid, ovf, {oa(), ob()});
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step;
      if (bus.out_valid) extra++;
    end
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL rst_stale: got %0d outputs exp 0", extra);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(0, 0), mk(0, 0), 0, 0, 1'b0, 1'b0);
    test_reset;
    test_basic;
    test_inverse;
    test_overflow;
    test_ovf_clear;
    test_scale;
    test_back_to_back;
    test_rst_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
